// File: rtl/apb_spi_flash_reader_if.sv
// APB bus bundle between the flash reader (requester) and the SPI host.
// Clock and active-low reset travel with the bus as interface ports.
interface apb_spi_flash_reader_if (
  input logic pclk,
  input logic preset_n
);
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pwuser;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport requester (
    input  pclk, preset_n,
    input  prdata, pready, pslverr,
    output paddr, psel, penable, pwrite,
    output pwdata, pstrb, pprot, pwuser
  );

  modport completer (
    input  pclk, preset_n,
    input  paddr, psel, penable, pwrite,
    input  pwdata, pstrb, pprot, pwuser,
    output prdata, pready, pslverr
  );

  modport master (
    input  pclk, preset_n,
    input  prdata, pready, pslverr,
    output paddr, psel, penable, pwrite,
    output pwdata, pstrb, pprot, pwuser
  );

  modport slave (
    input  pclk, preset_n,
    input  paddr, psel, penable, pwrite,
    input  pwdata, pstrb, pprot, pwuser,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_spi_flash_reader.sv
// Reads len_words 32-bit words from SPI flash by driving an APB SPI host.
// Ports: apb (requester bus + pclk/preset_n), start/flash_addr/len_words
// request, rd_data/rd_valid/rd_ready word stream, busy/done/err status.
module apb_spi_flash_reader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [31:0] SCK_DIV   = 32'd4
) (
  apb_spi_flash_reader_if.requester apb,
  input  logic        start,
  input  logic [23:0] flash_addr,
  input  logic [15:0] len_words,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [31:0] OFF_CLK   = 32'h00;
  localparam logic [31:0] OFF_DATA  = 32'h20;
  localparam logic [31:0] OFF_CS    = 32'h40;
  localparam logic [31:0] OFF_STAT  = 32'h60;
  localparam logic [31:0] OFF_BURST = 32'hA0;
  localparam logic [31:0] OFF_RXBUF = 32'h100;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP_DIV,
    S_CS_LOW,
    S_CMD,
    S_POLL,
    S_BURST_LEN,
    S_RXREAD,
    S_OUT_WAIT,
    S_CS_HIGH,
    S_FINISH
  } state_e;

  state_e      state_q, state_d;
  state_e      ret_q, ret_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] rem_q, rem_d;
  logic [5:0]  widx_q, widx_d;
  logic [6:0]  clen_q, clen_d;
  logic [1:0]  bidx_q, bidx_d;
  logic        psel_q, psel_d;
  logic        pen_q, pen_d;
  logic        pwr_q, pwr_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        xreq;
  logic        xwr;
  logic [31:0] xoff;
  logic [31:0] xdata;
  logic        cmpl;
  logic [6:0]  n_chunk;
  logic [7:0]  cmd_byte;

  always_ff @(posedge apb.pclk or negedge apb.preset_n) begin
    if (!apb.preset_n) begin
      state_q  <= S_IDLE;
      ret_q    <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      widx_q   <= '0;
      clen_q   <= '0;
      bidx_q   <= '0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwr_q    <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      widx_q   <= widx_d;
      clen_q   <= clen_d;
      bidx_q   <= bidx_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwr_q    <= pwr_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    widx_d   = widx_q;
    clen_d   = clen_q;
    bidx_d   = bidx_q;
    psel_d   = psel_q;
    pen_d    = pen_q;
    pwr_d    = pwr_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    xreq     = 1'b0;
    xwr      = 1'b0;
    xoff     = '0;
    xdata    = '0;
    cmpl     = psel_q & pen_q & apb.pready;
    n_chunk  = (rem_q > 16'd64) ? 7'd64 : rem_q[6:0];

    unique case (bidx_q)
      2'd0:    cmd_byte = 8'h03;
      2'd1:    cmd_byte = addr_q[23:16];
      2'd2:    cmd_byte = addr_q[15:8];
      default: cmd_byte = addr_q[7:0];
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = flash_addr;
          rem_d  = len_words;
          err_d  = 1'b0;
          if (len_words == 16'd0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = S_SETUP_DIV;
          end
        end
      end
      S_SETUP_DIV: begin
        xreq  = 1'b1;
        xwr   = 1'b1;
        xoff  = OFF_CLK;
        xdata = SCK_DIV;
        if (cmpl) state_d = S_CS_LOW;
      end
      S_CS_LOW: begin
        xreq  = 1'b1;
        xwr   = 1'b1;
        xoff  = OFF_CS;
        xdata = 32'd0;
        if (cmpl) begin
          bidx_d  = 2'd0;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        xreq  = 1'b1;
        xwr   = 1'b1;
        xoff  = OFF_DATA;
        xdata = {24'd0, cmd_byte};
        if (cmpl) begin
          ret_d   = (bidx_q == 2'd3) ? S_BURST_LEN : S_CMD;
          bidx_d  = bidx_q + 2'd1;
          state_d = S_POLL;
        end
      end
      S_POLL: begin
        xreq = 1'b1;
        xoff = OFF_STAT;
        if (cmpl && !apb.prdata[0]) state_d = ret_q;
      end
      S_BURST_LEN: begin
        xreq  = 1'b1;
        xwr   = 1'b1;
        xoff  = OFF_BURST;
        xdata = {23'd0, n_chunk, 2'b00};
        if (cmpl) begin
          clen_d  = n_chunk;
          widx_d  = 6'd0;
          ret_d   = S_RXREAD;
          state_d = S_POLL;
        end
      end
      S_RXREAD: begin
        xreq = 1'b1;
        xoff = OFF_RXBUF + {24'd0, widx_q, 2'b00};
        if (cmpl) begin
          rdata_d  = apb.prdata;
          rvalid_d = 1'b1;
          state_d  = S_OUT_WAIT;
        end
      end
      S_OUT_WAIT: begin
        // Bus stays idle until the held word is taken.
        if (rd_ready) begin
          rvalid_d = 1'b0;
          rem_d    = rem_q - 16'd1;
          if ({1'b0, widx_q} == clen_q - 7'd1) begin
            state_d = (rem_q == 16'd1) ? S_CS_HIGH : S_BURST_LEN;
          end else begin
            widx_d  = widx_q + 6'd1;
            state_d = S_RXREAD;
          end
        end
      end
      S_CS_HIGH: begin
        xreq  = 1'b1;
        xwr   = 1'b1;
        xoff  = OFF_CS;
        xdata = 32'd1;
        if (cmpl) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // A slave error aborts everything except the closing CS release.
    if (cmpl && apb.pslverr && state_q != S_CS_HIGH) begin
      err_d    = 1'b1;
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
      state_d  = S_CS_HIGH;
    end

    // Launch from idle only, so a completed transfer is always
    // followed by one cycle with psel low.
    if (xreq) begin
      if (!psel_q) begin
        psel_d   = 1'b1;
        pen_d    = 1'b0;
        pwr_d    = xwr;
        paddr_d  = BASE_ADDR + xoff;
        pwdata_d = xdata;
      end else if (!pen_q) begin
        pen_d = 1'b1;
      end else if (apb.pready) begin
        psel_d = 1'b0;
        pen_d  = 1'b0;
      end
    end
  end

  assign apb.psel    = psel_q;
  assign apb.penable = pen_q;
  assign apb.pwrite  = pwr_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.pstrb   = 4'hF;
  assign apb.pprot   = 3'd0;
  assign apb.pwuser  = 1'b0;
  assign rd_data     = rdata_q;
  assign rd_valid    = rvalid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_apb_spi_flash_reader.sv
// Directed bench for apb_spi_flash_reader with an APB SPI-host model.
// The model logs bus writes/reads and serves flash words from a pattern.
module tb_apb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] flash_addr = '0;
  logic [15:0] len_words = '0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b1;
  logic        busy, done, err;

  always #5 clk = ~clk;

  apb_spi_flash_reader_if apb_if (.pclk(clk), .preset_n(rst_n));

  apb_spi_flash_reader #(.BASE_ADDR(32'h0), .SCK_DIV(32'd4)) dut (
    .apb       (apb_if),
    .start     (start),
    .flash_addr(flash_addr),
    .len_words (len_words),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
  } xact_t;

  xact_t       log_q[$];
  logic [31:0] words[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          n_polls = 0;
  int          proto_err = 0;
  int          xfer_cnt = 0;
  int          err_idx = -1;
  int          wcnt = 0;
  logic [2:0]  busy_cnt = '0;
  logic [23:0] ptr = '0, chunk_base = '0, asm_a = '0;
  int          dcnt = 0;
  logic        prev_cmpl = 1'b0, psel_prev = 1'b0;
  logic        cmpl;

  function automatic logic [7:0] fbyte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] fword(input logic [23:0] a);
    return {fbyte(a + 24'd3), fbyte(a + 24'd2),
            fbyte(a + 24'd1), fbyte(a)};
  endfunction

  // Completer model: odd-numbered transfers take one wait state.
  always @* begin
    apb_if.pready  = apb_if.psel && apb_if.penable &&
                     (wcnt >= (xfer_cnt % 2));
    apb_if.pslverr = apb_if.psel && apb_if.penable &&
                     (xfer_cnt == err_idx);
    apb_if.prdata  = 32'd0;
    if (apb_if.paddr == 32'h60)
      apb_if.prdata = {31'd0, busy_cnt != 3'd0};
    else if (apb_if.paddr >= 32'h100)
      apb_if.prdata = fword(chunk_base +
                            (apb_if.paddr[23:0] - 24'h100));
  end

  assign cmpl = apb_if.psel && apb_if.penable && apb_if.pready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt  <= 0;
      wcnt      <= 0;
      busy_cnt  <= '0;
      dcnt      <= 0;
      prev_cmpl <= 1'b0;
      psel_prev <= 1'b0;
    end else begin
      prev_cmpl <= cmpl;
      psel_prev <= apb_if.psel;
      if (prev_cmpl && apb_if.psel) proto_err <= proto_err + 1;
      if (apb_if.penable && !apb_if.psel) proto_err <= proto_err + 1;
      if (apb_if.psel && !psel_prev && apb_if.penable)
        proto_err <= proto_err + 1;
      if (done && busy) proto_err <= proto_err + 1;
      if (apb_if.pstrb != 4'hF) proto_err <= proto_err + 1;
      if (cmpl) begin
        xfer_cnt <= xfer_cnt + 1;
        wcnt     <= 0;
        if (apb_if.paddr == 32'h60) begin
          n_polls <= n_polls + 1;
          if (busy_cnt != 3'd0) busy_cnt <= busy_cnt - 3'd1;
        end else begin
          log_q.push_back('{apb_if.paddr,
                            apb_if.pwrite ? apb_if.pwdata : 32'd0,
                            apb_if.pwrite});
          if (apb_if.pwrite && apb_if.paddr == 32'h40) begin
            busy_cnt <= '0;
            dcnt     <= 0;
          end
          if (apb_if.pwrite && apb_if.paddr == 32'h20) begin
            busy_cnt <= 3'd3;
            dcnt     <= dcnt + 1;
            if (dcnt == 1) asm_a[23:16] <= apb_if.pwdata[7:0];
            if (dcnt == 2) asm_a[15:8] <= apb_if.pwdata[7:0];
            if (dcnt == 3) ptr <= {asm_a[23:8], apb_if.pwdata[7:0]};
          end
          if (apb_if.pwrite && apb_if.paddr == 32'hA0) begin
            busy_cnt   <= 3'd3;
            chunk_base <= ptr;
            ptr        <= ptr + apb_if.pwdata[23:0];
          end
        end
      end else if (apb_if.psel && apb_if.penable) begin
        wcnt <= wcnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rd_valid && rd_ready) words.push_back(rd_data);
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic do_start(input logic [23:0] a, input logic [15:0] n);
    @(negedge clk);
    flash_addr = a;
    len_words  = n;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget,
                           output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({apb_if.psel, apb_if.penable, apb_if.pwrite, rd_valid,
         busy, done, err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {apb_if.psel, apb_if.penable, apb_if.pwrite,
                rd_valid, busy, done, err});
    end
    n_tests++;
    if ({apb_if.paddr, apb_if.pwdata, rd_data} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_data: paddr=%h pwdata=%h rd_data=%h want 0",
               apb_if.paddr, apb_if.pwdata, rd_data);
    end
    n_tests++;
    if (apb_if.pstrb !== 4'hF || apb_if.pprot !== 3'd0 ||
        apb_if.pwuser !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_const: pstrb=%h pprot=%h pwuser=%b",
               apb_if.pstrb, apb_if.pprot, apb_if.pwuser);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_read;
    logic [31:0] ea[10] = '{32'h00, 32'h40, 32'h20, 32'h20, 32'h20,
                            32'h20, 32'hA0, 32'h100, 32'h104, 32'h40};
    logic [31:0] ed[10] = '{32'd4, 32'd0, 32'h03, 32'h12, 32'h34,
                            32'h56, 32'd8, 32'd0, 32'd0, 32'd1};
    logic        ew[10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1};
    int d0, p0;
    bit ok;
    log_q.delete();
    words.delete();
    err_idx  = -1;
    rd_ready = 1'b1;
    d0 = done_cnt;
    p0 = n_polls;
    do_start(24'h123456, 16'd2);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy: got %b want 1", busy);
    end
    wait_done(d0 + 1, 3000, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_timeout: done_cnt=%0d want %0d",
               done_cnt, d0 + 1);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (done_cnt !== d0 + 1 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_end: dones=%0d busy=%b err=%b want 1/0/0",
               done_cnt - d0, busy, err);
    end
    n_tests++;
    if (log_q.size() != 10) begin
      n_fail++;
      $display("FAIL basic_nlog: got %0d want 10", log_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_tests++;
        if (log_q[i].a !== ea[i] || log_q[i].d !== ed[i] ||
            log_q[i].w !== ew[i]) begin
          n_fail++;
          $display("FAIL basic_xact%0d: got %h/%h/%b want %h/%h/%b", i,
                   log_q[i].a, log_q[i].d, log_q[i].w,
                   ea[i], ed[i], ew[i]);
        end
      end
    end
    n_tests++;
    if (n_polls - p0 != 20) begin
      n_fail++;
      $display("FAIL basic_polls: got %0d want 20", n_polls - p0);
    end
    n_tests++;
    if (words.size() != 2) begin
      n_fail++;
      $display("FAIL basic_nwords: got %0d want 2", words.size());
    end else begin
      n_tests++;
      if (words[0] !== 32'h37363938 || words[1] !== 32'h33323534) begin
        n_fail++;
        $display("FAIL basic_words: got %h %h want 37363938 33323534",
                 words[0], words[1]);
      end
    end
  endtask

  task automatic test_chunking;
    logic [31:0] bl[$];
    logic [31:0] cs[$];
    int d0;
    bit ok;
    log_q.delete();
    words.delete();
    rd_ready = 1'b1;
    d0 = done_cnt;
    do_start(24'h000100, 16'd130);
    wait_done(d0 + 1, 8000, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL chunk_timeout: done_cnt=%0d want %0d",
               done_cnt, d0 + 1);
    end
    foreach (log_q[i]) begin
      if (log_q[i].a == 32'hA0) bl.push_back(log_q[i].d);
      if (log_q[i].a == 32'h40) cs.push_back(log_q[i].d);
    end
    n_tests++;
    if (bl.size() != 3) begin
      n_fail++;
      $display("FAIL chunk_nburst: got %0d want 3", bl.size());
    end else if (bl[0] !== 32'd256 || bl[1] !== 32'd256 ||
                 bl[2] !== 32'd8) begin
      n_fail++;
      $display("FAIL chunk_burst: got %0d %0d %0d want 256 256 8",
               bl[0], bl[1], bl[2]);
    end
    n_tests++;
    if (cs.size() != 2 || cs[0] !== 32'd0 || cs[cs.size()-1] !== 32'd1)
    begin
      n_fail++;
      $display("FAIL chunk_cs: got %0d CS writes want 2 (0 then 1)",
               cs.size());
    end
    n_tests++;
    if (words.size() != 130) begin
      n_fail++;
      $display("FAIL chunk_nwords: got %0d want 130", words.size());
    end else begin
      for (int k = 0; k < 130; k++) begin
        n_tests++;
        if (words[k] !== fword(24'h000100 + 24'(4 * k))) begin
          n_fail++;
          $display("FAIL chunk_word%0d: got %h want %h", k, words[k],
                   fword(24'h000100 + 24'(4 * k)));
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] held;
    int d0;
    bit ok, bad;
    words.delete();
    rd_ready = 1'b0;
    d0 = done_cnt;
    do_start(24'h000200, 16'd3);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = rd_valid;
    end
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = rd_valid;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bp_timeout: rd_valid=%b want 1", rd_valid);
    end
    held = rd_data;
    bad  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (apb_if.psel !== 1'b0 || rd_data !== held || rd_valid !== 1'b1)
        bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL bp_hold: psel=%b rd_data=%h want 0 and %h",
               apb_if.psel, rd_data, held);
    end
    n_tests++;
    if (held !== fword(24'h000204)) begin
      n_fail++;
      $display("FAIL bp_word1: got %h want %h", held, fword(24'h000204));
    end
    rd_ready = 1'b1;
    wait_done(d0 + 1, 2000, ok);
    n_tests++;
    if (!ok || words.size() != 3) begin
      n_fail++;
      $display("FAIL bp_resume: got %0d words want 3", words.size());
    end else if (words[1] !== fword(24'h000204) ||
                 words[2] !== fword(24'h000208)) begin
      n_fail++;
      $display("FAIL bp_resume: got %h %h want %h %h", words[1],
               words[2], fword(24'h000204), fword(24'h000208));
    end
  endtask

  task automatic test_slverr;
    int d0;
    bit ok;
    log_q.delete();
    words.delete();
    rd_ready = 1'b1;
    d0 = done_cnt;
    err_idx = xfer_cnt + 12;
    do_start(24'h123456, 16'd4);
    wait_done(d0 + 1, 3000, ok);
    err_idx = -1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (!ok || err !== 1'b1 || done_cnt !== d0 + 1) begin
      n_fail++;
      $display("FAIL slverr_end: err=%b dones=%0d want 1 and 1",
               err, done_cnt - d0);
    end
    n_tests++;
    if (log_q.size() != 6) begin
      n_fail++;
      $display("FAIL slverr_nlog: got %0d want 6", log_q.size());
    end else if (log_q[4].d !== 32'h34 || log_q[5].a !== 32'h40 ||
                 log_q[5].d !== 32'd1) begin
      n_fail++;
      $display("FAIL slverr_tail: got %h %h=%h want 34 40=1",
               log_q[4].d, log_q[5].a, log_q[5].d);
    end
    n_tests++;
    if (words.size() != 0) begin
      n_fail++;
      $display("FAIL slverr_words: got %0d want 0", words.size());
    end
    do_start(24'h0, 16'd0);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL slverr_clear: got %b want 0", err);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_len_zero;
    int x0, d0;
    bit sawsel;
    x0 = xfer_cnt;
    d0 = done_cnt;
    do_start(24'h000300, 16'd0);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_done: done=%b busy=%b want 1 0", done, busy);
    end
    sawsel = apb_if.psel;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sawsel |= apb_if.psel | busy;
    end
    n_tests++;
    if (sawsel || xfer_cnt != x0 || done_cnt != d0 + 1) begin
      n_fail++;
      $display("FAIL len0_quiet: xfers=%0d dones=%0d want 0 1",
               xfer_cnt - x0, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid;
    int nlog, d0;
    bit ok;
    rd_ready = 1'b1;
    d0 = done_cnt;
    do_start(24'h000400, 16'd64);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = apb_if.psel && apb_if.penable && apb_if.paddr == 32'h114;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rstmid_reach: paddr=%h want 114", apb_if.paddr);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({apb_if.psel, apb_if.penable, apb_if.pwrite, rd_valid,
         busy, done, err} !== 7'b0 ||
        {apb_if.paddr, apb_if.pwdata, rd_data} !== 96'd0) begin
      n_fail++;
      $display("FAIL rstmid_out: ctl=%b paddr=%h pwdata=%h rd=%h want 0",
               {apb_if.psel, apb_if.penable, apb_if.pwrite, rd_valid,
                busy, done, err}, apb_if.paddr, apb_if.pwdata, rd_data);
    end
    nlog = log_q.size();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_tests++;
    if (log_q.size() != nlog || apb_if.psel !== 1'b0 ||
        busy !== 1'b0 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL rstmid_after: new=%0d psel=%b busy=%b want 0 0 0",
               log_q.size() - nlog, apb_if.psel, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_chunking();
    test_backpressure();
    test_slverr();
    test_len_zero();
    test_reset_mid();
    n_tests++;
    if (proto_err != 0) begin
      n_fail++;
      $display("FAIL apb_protocol: got %0d violations want 0", proto_err);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
